// File: rtl/fc_pkg.sv
// Shared FC-layer definitions: sequencer state encoding, Q5.10 constants and
// the saturating add used by every FC accumulator.
package fc_pkg;

    localparam int Q_W       = 16;
    localparam int FRAC_BITS = 10;
    localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_LOAD,
        S_MUL,
        S_ACC,
        S_WRITE,
        S_FIN
    } fc_seq_state_t;

    // One guard bit is enough: the two top bits disagree exactly on overflow.
    function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] a,
                                               input logic [Q_W-1:0] b);
        logic [Q_W:0] s;
        s = {a[Q_W-1], a} + {b[Q_W-1], b};
        case (s[Q_W:Q_W-1])
            2'b01:   return SAT_MAX;
            2'b10:   return SAT_MIN;
            default: return s[Q_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/fc_sat_acc.sv
// 16-bit saturating Q5.10 accumulator with synchronous clear and an optional
// ReLU on the presented result.
module fc_sat_acc
    import fc_pkg::*;
#(
    parameter bit RELU = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_i,
    input  logic           add_i,
    input  logic [Q_W-1:0] addend_i,
    output logic [Q_W-1:0] acc_o,
    output logic [Q_W-1:0] res_o
);

    logic [Q_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (add_i)
            acc_d = sat_add(acc_q, addend_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;
    assign res_o = (RELU && acc_q[Q_W-1]) ? '0 : acc_q;

endmodule

// File: rtl/fc_mac_sequencer.sv
// Walks a fully-connected layer through one shared serial multiplier: fetch an
// input/weight pair, run one product, accumulate, and write one word per neuron.
module fc_mac_sequencer
    import fc_pkg::*;
#(
    parameter int N      = 16,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10,
    parameter bit RELU   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_inputs,
    input  logic [CNT_W-1:0]  num_outputs,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [N-1:0]      in_data,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [N-1:0]      w_data,
    output logic [N-1:0]      mul_M,
    output logic [N-1:0]      mul_R,
    output logic              mul_enable,
    output logic              mul_reset,
    input  logic              mul_finish,
    input  logic [N-1:0]      mul_result,
    output logic [ADDR_W-1:0] out_addr,
    output logic [N-1:0]      out_data,
    output logic              out_we,
    output logic              busy,
    output logic              done
);

    fc_seq_state_t     state_q, state_d;
    logic [CNT_W-1:0]  k_q, k_d, j_q, j_d, kn_q, kn_d, jn_q, jn_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d, wptr_q, wptr_d;
    logic [N-1:0]      mul_m_q, mul_m_d, mul_r_q, mul_r_d;
    logic              acc_clr, acc_add;
    logic [N-1:0]      acc_val, acc_res;

    fc_sat_acc #(.RELU(RELU)) u_acc (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (acc_clr),
        .add_i    (acc_add),
        .addend_i (mul_result),
        .acc_o    (acc_val),
        .res_o    (acc_res)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        j_d        = j_q;
        kn_d       = kn_q;
        jn_d       = jn_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        wptr_d     = wptr_q;
        mul_m_d    = mul_m_q;
        mul_r_d    = mul_r_q;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        in_addr    = '0;
        w_addr     = '0;
        mul_M      = mul_m_q;
        mul_R      = mul_r_q;
        mul_enable = 1'b0;
        mul_reset  = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        out_we     = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CHECK;
                    kn_d       = num_inputs;
                    jn_d       = num_outputs;
                    in_base_d  = in_base;
                    out_base_d = out_base;
                    wptr_d     = w_base;
                    k_d        = '0;
                    j_d        = '0;
                end
            end
            S_CHECK: begin
                acc_clr = 1'b1;
                if (jn_q == '0)
                    state_d = S_FIN;
                else if (kn_q == '0)
                    state_d = S_WRITE;
                else
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                in_addr = in_base_q + ADDR_W'(k_q);
                w_addr  = wptr_q;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Memory data is live this cycle; pass it straight through so the
                // multiplier loads real operands on this edge, and hold it after.
                mul_M      = w_data;
                mul_R      = in_data;
                mul_m_d    = w_data;
                mul_r_d    = in_data;
                mul_enable = 1'b1;
                mul_reset  = 1'b1;
                state_d    = S_MUL;
            end
            S_MUL: begin
                mul_enable = 1'b1;
                if (mul_finish)
                    state_d = S_ACC;
            end
            S_ACC: begin
                acc_add = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                k_d     = k_q + 1'b1;
                state_d = (k_q == kn_q - 1'b1) ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                out_we   = 1'b1;
                out_addr = out_base_q + ADDR_W'(j_q);
                out_data = acc_res;
                acc_clr  = 1'b1;
                k_d      = '0;
                j_d      = j_q + 1'b1;
                if (j_q == jn_q - 1'b1)
                    state_d = S_FIN;
                else if (kn_q == '0)
                    state_d = S_WRITE;
                else
                    state_d = S_FETCH;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            j_q        <= '0;
            kn_q       <= '0;
            jn_q       <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            wptr_q     <= '0;
            mul_m_q    <= '0;
            mul_r_q    <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            j_q        <= j_d;
            kn_q       <= kn_d;
            jn_q       <= jn_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            wptr_q     <= wptr_d;
            mul_m_q    <= mul_m_d;
            mul_r_q    <= mul_r_d;
        end
    end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Scoreboard bench: two sequencers (ReLU on / off) share memories and stimulus,
// each with its own serial-multiplier model; a monitor checks every write.
module tb_fc_mac_sequencer;
    localparam int N = 16;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [9:0] num_inputs = '0, num_outputs = '0;
    logic [9:0] in_base = '0, w_base = '0, out_base = '0;

    logic [1:0][9:0]  in_addr_v, w_addr_v, out_addr_v;
    logic [1:0][15:0] mul_M_v, mul_R_v, out_data_v;
    logic [1:0]       mul_enable_v, mul_reset_v, out_we_v, busy_v, done_v;

    logic [15:0] in_mem [1024];
    logic [15:0] w_mem  [1024];
    wr_t exp_q [2][$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> 10;
        if (p > 32767)  return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return p[15:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_h
        logic [15:0] in_d = '0, w_d = '0;
        logic [15:0] m_q = '0, r_q = '0;
        logic [4:0]  cnt = '0;
        logic        fin = 1'b0;
        logic [15:0] res;
        wr_t         e;

        assign res = qmul(m_q, r_q);

        always @(posedge clk) begin
            in_d <= in_mem[in_addr_v[g]];
            w_d  <= w_mem[w_addr_v[g]];
        end

        always @(posedge clk) begin
            if (mul_enable_v[g]) begin
                if (mul_reset_v[g]) begin
                    m_q <= mul_M_v[g];
                    r_q <= mul_R_v[g];
                    cnt <= '0;
                    fin <= 1'b0;
                end else if (!fin) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 5'(N - 1)) fin <= 1'b1;
                end
            end
        end

        fc_mac_sequencer #(.N(N), .ADDR_W(10), .CNT_W(10), .RELU(g == 0)) u_dut (
            .clk         (clk),
            .reset       (rst_n),
            .start       (start),
            .num_inputs  (num_inputs),
            .num_outputs (num_outputs),
            .in_base     (in_base),
            .w_base      (w_base),
            .out_base    (out_base),
            .in_addr     (in_addr_v[g]),
            .in_data     (in_d),
            .w_addr      (w_addr_v[g]),
            .w_data      (w_d),
            .mul_M       (mul_M_v[g]),
            .mul_R       (mul_R_v[g]),
            .mul_enable  (mul_enable_v[g]),
            .mul_reset   (mul_reset_v[g]),
            .mul_finish  (fin),
            .mul_result  (res),
            .out_addr    (out_addr_v[g]),
            .out_data    (out_data_v[g]),
            .out_we      (out_we_v[g]),
            .busy        (busy_v[g]),
            .done        (done_v[g])
        );

        always @(negedge clk) begin
            if (rst_n) begin
                if (out_we_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("unexpected_write%0d", g),
                            {out_addr_v[g], out_data_v[g]}, 64'hDEAD);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("write%0d", g), {out_addr_v[g], out_data_v[g]}, {e.addr, e.data});
                    end
                end
                if (done_v[g])
                    chk($sformatf("pending_at_done%0d", g), 64'(exp_q[g].size()), 64'd0);
            end
        end
    end

    task automatic expect_wr(input logic [9:0] a, input logic [15:0] raw);
        wr_t e0, e1;
        e0.addr = a; e0.data = raw[15] ? 16'h0000 : raw;
        e1.addr = a; e1.data = raw;
        exp_q[0].push_back(e0);
        exp_q[1].push_back(e1);
    endtask

    task automatic check_idle(input string nm);
        for (int g = 0; g < 2; g++) begin
            chk({nm, "_bus"}, {in_addr_v[g], w_addr_v[g], out_addr_v[g], mul_M_v[g]}, 64'd0);
            chk({nm, "_ctl"}, {mul_R_v[g], out_data_v[g], mul_enable_v[g], mul_reset_v[g],
                               out_we_v[g], busy_v[g], done_v[g]}, 64'd0);
        end
    endtask

    task automatic run_layer(input string nm, input int K, input int J, input logic [9:0] ib,
                             input logic [9:0] wb, input logic [9:0] ob, input bit glitch);
        int cyc;
        int exp_lat;
        exp_lat = 2 + J * (K * (N + 4) + 1);
        start = 1'b1;
        num_inputs = 10'(K); num_outputs = 10'(J);
        in_base = ib; w_base = wb; out_base = ob;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = glitch && (cyc == 4);
            // Config is free to change after the accepted start.
            num_inputs = 10'd2; num_outputs = 10'd3;
            in_base = 10'h3C0; w_base = 10'h3D0; out_base = 10'h300;
        end while (done_v == 2'b00 && cyc < 5000);
        chk({nm, "_latency"}, {62'(cyc), done_v}, {62'(exp_lat), 2'b11});
        @(negedge clk);
        chk({nm, "_idle_after"}, {busy_v, done_v, out_we_v}, 64'd0);
    endtask

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 2.0 * 3.0 = 6.0
        in_mem[10'h010] = 16'h0800; w_mem[10'h100] = 16'h0C00;
        expect_wr(10'h200, 16'h1800);
        run_layer("k1j1", 1, 1, 10'h010, 10'h100, 10'h200, 1'b0);

        // Rows of 0.5 and -1.0 against an all-ones input
        for (int i = 0; i < 3; i++) begin
            in_mem[10'h020 + i] = 16'h0400;
            w_mem[10'h120 + i]  = 16'h0200;
            w_mem[10'h123 + i]  = 16'hFC00;
        end
        expect_wr(10'h210, 16'h0600);
        expect_wr(10'h211, 16'hF400);
        run_layer("k3j2", 3, 2, 10'h020, 10'h120, 10'h210, 1'b0);

        for (int i = 0; i < 4; i++) begin
            in_mem[10'h030 + i] = 16'h1C00;
            w_mem[10'h140 + i]  = 16'h1C00;
            w_mem[10'h150 + i]  = 16'hE400;
        end
        expect_wr(10'h220, 16'h7FFF);
        run_layer("sat_pos", 4, 1, 10'h030, 10'h140, 10'h220, 1'b0);
        expect_wr(10'h230, 16'h8000);
        run_layer("sat_neg", 4, 1, 10'h030, 10'h150, 10'h230, 1'b0);

        // Pin at the negative rail, then climb back: -32,-32,+32,+1 -> 0x03FF
        in_mem[10'h050] = 16'h1C00; w_mem[10'h160] = 16'hE400;
        in_mem[10'h051] = 16'h1C00; w_mem[10'h161] = 16'hE400;
        in_mem[10'h052] = 16'h1C00; w_mem[10'h162] = 16'h1C00;
        in_mem[10'h053] = 16'h0400; w_mem[10'h163] = 16'h0400;
        expect_wr(10'h240, 16'h03FF);
        run_layer("sat_recover", 4, 1, 10'h050, 10'h160, 10'h240, 1'b0);

        run_layer("j0", 5, 0, 10'h000, 10'h000, 10'h250, 1'b0);

        // Output addresses wrap past the top of the address space
        expect_wr(10'h3FE, 16'h0000);
        expect_wr(10'h3FF, 16'h0000);
        expect_wr(10'h000, 16'h0000);
        run_layer("k0j3", 0, 3, 10'h000, 10'h000, 10'h3FE, 1'b0);

        expect_wr(10'h200, 16'h1800);
        run_layer("restart_ignored", 1, 1, 10'h010, 10'h100, 10'h200, 1'b1);

        // Abort inside the multiply phase
        start = 1'b1; num_inputs = 10'd1; num_outputs = 10'd1;
        in_base = 10'h010; w_base = 10'h100; out_base = 10'h200;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_in_mul", {62'd0, mul_enable_v}, 64'h3);
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done_v != 2'b00) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);

        expect_wr(10'h210, 16'h0600);
        expect_wr(10'h211, 16'hF400);
        run_layer("after_abort", 3, 2, 10'h020, 10'h120, 10'h210, 1'b0);

        chk("queue0_drained", 64'(exp_q[0].size()), 64'd0);
        chk("queue1_drained", 64'(exp_q[1].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
